// File: rtl/boot_pkg.sv
// Shared types for the boot/run sequencing path: FSM state encoding and
// default widths, common with the axi4_boot_check status mapping.
package boot_pkg;

    localparam int BOOT_EXIT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASSERT_RST = 3'd1,
        ST_RELEASE    = 3'd2,
        ST_RUN        = 3'd3,
        ST_DONE       = 3'd4,
        ST_TIMEOUT    = 3'd5
    } boot_state_e;

    function automatic logic state_is_busy(input boot_state_e s);
        return (s == ST_ASSERT_RST) || (s == ST_RELEASE) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/boot_run_sequencer.sv
// Sequences a RISC-V core out of reset on a boot request, then watches for
// end-of-computation or a run timeout and reports status plus a host irq.
module boot_run_sequencer
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int RST_CYCLES = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int EXIT_WIDTH = BOOT_EXIT_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] boot_addr_i,
    input  logic [CNT_WIDTH-1:0]  timeout_cycles_i,
    input  logic                  core_eoc_i,
    input  logic [EXIT_WIDTH-1:0] core_exit_i,
    output logic                  core_rst_o,
    output logic                  fetch_en_o,
    output logic [ADDR_WIDTH-1:0] boot_addr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [EXIT_WIDTH-1:0] exit_code_o,
    output logic [CNT_WIDTH-1:0]  run_cycles_o,
    output logic                  irq_o
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    boot_state_e          state_q;
    boot_state_e          state_d;
    logic                 start_q;
    logic [RCW-1:0]       rst_cnt;
    logic [CNT_WIDTH-1:0] timeout_q;

    logic                 start_edge;
    logic                 start_acc;
    logic                 to_hit;
    logic [CNT_WIDTH:0]   run_next;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        start_edge = start_i & ~start_q;
        start_acc  = start_edge && (state_q inside {ST_IDLE, ST_RUN, ST_DONE, ST_TIMEOUT});
        // One extra bit so a saturated counter can never alias onto the limit.
        run_next   = {1'b0, run_cycles_o} + (CNT_WIDTH + 1)'(1);
        to_hit     = (timeout_q != '0) && (run_next == {1'b0, timeout_q});

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_acc) state_d = ST_ASSERT_RST;
            end
            ST_ASSERT_RST: begin
                if (rst_cnt == RST_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_acc)       state_d = ST_ASSERT_RST;
                else if (core_eoc_i) state_d = ST_DONE;
                else if (to_hit)     state_d = ST_TIMEOUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            rst_cnt      <= '0;
            timeout_q    <= '0;
            core_rst_o   <= 1'b1;
            fetch_en_o   <= 1'b0;
            boot_addr_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
            exit_code_o  <= '0;
            run_cycles_o <= '0;
            irq_o        <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            core_rst_o <= !((state_d == ST_RELEASE) || (state_d == ST_RUN));
            fetch_en_o <= (state_d == ST_RUN);
            busy_o     <= state_is_busy(state_d);
            irq_o      <= (state_q == ST_RUN) &&
                          ((state_d == ST_DONE) || (state_d == ST_TIMEOUT));

            if (state_q == ST_ASSERT_RST) rst_cnt <= rst_cnt + RCW'(1);
            else                          rst_cnt <= '0;

            if (start_acc) begin
                boot_addr_o  <= boot_addr_i;
                timeout_q    <= timeout_cycles_i;
                done_o       <= 1'b0;
                timeout_o    <= 1'b0;
                exit_code_o  <= '0;
                run_cycles_o <= '0;
            end else if (state_q == ST_RUN) begin
                run_cycles_o <= sat_inc(run_cycles_o);
                if (core_eoc_i) begin
                    done_o      <= 1'b1;
                    exit_code_o <= core_exit_i;
                end else if (to_hit) begin
                    timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_run_sequencer.sv
// Directed bench for boot_run_sequencer: a vector table of boot/run scenarios
// plus hand-written sequences for held start, aborts, and reset mid-run.
`timescale 1ns/1ps
module tb_boot_run_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start_i;
    logic [63:0] boot_addr_i;
    logic [31:0] timeout_cycles_i;
    logic        core_eoc_i;
    logic [31:0] core_exit_i;
    logic        core_rst_o;
    logic        fetch_en_o;
    logic [63:0] boot_addr_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] exit_code_o;
    logic [31:0] run_cycles_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;
    int rel_cnt = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] tmo;
        int          eoc_at;
        logic [31:0] exit_v;
        logic        exp_done;
        logic        exp_to;
        logic [31:0] exp_run;
        logic [31:0] exp_exit;
    } vec_t;

    vec_t vecs[6];

    boot_run_sequencer #(
        .ADDR_WIDTH(64), .RST_CYCLES(16), .CNT_WIDTH(32), .EXIT_WIDTH(32)
    ) dut (
        .aclk(aclk), .areset(areset), .start_i(start_i), .boot_addr_i(boot_addr_i),
        .timeout_cycles_i(timeout_cycles_i), .core_eoc_i(core_eoc_i), .core_exit_i(core_exit_i),
        .core_rst_o(core_rst_o), .fetch_en_o(fetch_en_o), .boot_addr_o(boot_addr_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .exit_code_o(exit_code_o),
        .run_cycles_o(run_cycles_o), .irq_o(irq_o)
    );

    always #5 aclk = ~aclk;

    // RELEASE is the only state with both core_rst_o and fetch_en_o low.
    always @(negedge aclk) begin
        if (areset === 1'b0 && core_rst_o === 1'b0 && fetch_en_o === 1'b0)
            rel_cnt <= rel_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_boot(input logic [63:0] addr, input logic [31:0] tmo, input int glitch_k);
        int rst_hi;
        int fetch_k;
        rst_hi  = 0;
        fetch_k = 0;
        boot_addr_i      = addr;
        timeout_cycles_i = tmo;
        start_i          = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                start_i          = 1'b0;
                boot_addr_i      = ~addr;
                timeout_cycles_i = 32'd7;
                chk("boot_k1_core_rst", core_rst_o, 1);
                chk("boot_k1_fetch", fetch_en_o, 0);
                chk("boot_k1_busy", busy_o, 1);
                chk("boot_k1_done", done_o, 0);
                chk("boot_k1_timeout", timeout_o, 0);
                chk("boot_k1_run", run_cycles_o, 0);
                chk("boot_k1_exit", exit_code_o, 0);
            end
            if (glitch_k != 0 && k == glitch_k)     start_i = 1'b1;
            if (glitch_k != 0 && k == glitch_k + 1) start_i = 1'b0;
            if (core_rst_o) rst_hi++;
            if (fetch_en_o && fetch_k == 0) fetch_k = k;
            if (k == 17) begin
                chk("release_rst_low", core_rst_o, 0);
                chk("release_fetch_low", fetch_en_o, 0);
                chk("release_boot_addr", boot_addr_o, addr);
            end
        end
        chk("rst_hold_cycles", rst_hi, 16);
        chk("fetch_latency", fetch_k, 18);
        chk("run_boot_addr", boot_addr_o, addr);
        chk("run_start_count", run_cycles_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit fin;
        fin = 1'b0;
        do_boot(v.addr, v.tmo, 0);
        for (int c = 0; c < 1000 && !fin; c++) begin
            if (v.eoc_at != 0 && c == v.eoc_at - 1) begin
                core_eoc_i  = 1'b1;
                core_exit_i = v.exit_v;
            end
            @(negedge aclk);
            core_eoc_i  = 1'b0;
            core_exit_i = 32'hBAD0_0000;
            if (done_o || timeout_o) fin = 1'b1;
        end
        chk($sformatf("v%0d_finished", idx), fin, 1);
        chk($sformatf("v%0d_done", idx), done_o, v.exp_done);
        chk($sformatf("v%0d_timeout", idx), timeout_o, v.exp_to);
        chk($sformatf("v%0d_run_cycles", idx), run_cycles_o, v.exp_run);
        chk($sformatf("v%0d_exit", idx), exit_code_o, v.exp_exit);
        chk($sformatf("v%0d_irq", idx), irq_o, 1);
        chk($sformatf("v%0d_core_rst", idx), core_rst_o, 1);
        chk($sformatf("v%0d_fetch", idx), fetch_en_o, 0);
        chk($sformatf("v%0d_busy", idx), busy_o, 0);
        @(negedge aclk);
        chk($sformatf("v%0d_irq_one_cycle", idx), irq_o, 0);
        chk($sformatf("v%0d_run_frozen", idx), run_cycles_o, v.exp_run);
    endtask

    initial begin
        int r0;
        bit ok;

        vecs[0] = '{64'h0000_0000_8000_0000, 32'd0,  100, 32'h0,         1'b1, 1'b0, 32'd100, 32'h0};
        vecs[1] = '{64'h0000_0000_0000_1000, 32'd50, 0,   32'h0,         1'b0, 1'b1, 32'd50,  32'h0};
        vecs[2] = '{64'hDEAD_BEEF_0000_1000, 32'd30, 30,  32'h55,        1'b1, 1'b0, 32'd30,  32'h55};
        vecs[3] = '{64'h0000_0000_0000_2000, 32'd20, 10,  32'hA5A5_0001, 1'b1, 1'b0, 32'd10,  32'hA5A5_0001};
        vecs[4] = '{64'h0000_0000_0000_0004, 32'd1,  0,   32'h0,         1'b0, 1'b1, 32'd1,   32'h0};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 32'd0,  1,   32'hFFFF_FFFF, 1'b1, 1'b0, 32'd1,   32'hFFFF_FFFF};

        areset           = 1'b1;
        start_i          = 1'b0;
        boot_addr_i      = 64'h0;
        timeout_cycles_i = 32'h0;
        core_eoc_i       = 1'b0;
        core_exit_i      = 32'h0;
        repeat (3) @(negedge aclk);
        chk("rst_core_rst", core_rst_o, 1);
        chk("rst_fetch", fetch_en_o, 0);
        chk("rst_boot_addr", boot_addr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_exit", exit_code_o, 0);
        chk("rst_run", run_cycles_o, 0);
        chk("rst_irq", irq_o, 0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        chk("idle_busy", busy_o, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // EOC while DONE must not disturb latched status.
        core_eoc_i  = 1'b1;
        core_exit_i = 32'h0000_1234;
        @(negedge aclk);
        core_eoc_i = 1'b0;
        @(negedge aclk);
        chk("done_eoc_exit_kept", exit_code_o, 32'hFFFF_FFFF);
        chk("done_eoc_done_kept", done_o, 1);
        chk("done_eoc_no_irq", irq_o, 0);

        // Held start boots once; a later edge boots again and clears status.
        r0 = rel_cnt;
        boot_addr_i      = 64'h0000_0000_0000_3000;
        timeout_cycles_i = 32'd100;
        start_i          = 1'b1;
        repeat (2000) @(negedge aclk);
        chk("held_boot_count", rel_cnt - r0, 1);
        chk("held_timeout", timeout_o, 1);
        chk("held_run_cycles", run_cycles_o, 100);
        chk("held_busy", busy_o, 0);
        start_i = 1'b0;
        repeat (5) @(negedge aclk);
        timeout_cycles_i = 32'd0;
        start_i = 1'b1;
        @(negedge aclk);
        chk("second_clears_timeout", timeout_o, 0);
        chk("second_busy", busy_o, 1);
        repeat (20) @(negedge aclk);
        chk("second_boot_count", rel_cnt - r0, 2);
        chk("second_fetch", fetch_en_o, 1);
        start_i = 1'b0;
        repeat (10) @(negedge aclk);
        chk("second_run_counting", run_cycles_o, 13);

        // Abort from RUN, with an ignored edge inside ASSERT_RST.
        r0 = rel_cnt;
        do_boot(64'h0000_0000_0000_5000, 32'd0, 5);
        chk("abort_single_release", rel_cnt - r0, 1);

        // Start and EOC in the same RUN cycle: reboot wins.
        repeat (5) @(negedge aclk);
        start_i     = 1'b1;
        core_eoc_i  = 1'b1;
        core_exit_i = 32'd77;
        @(negedge aclk);
        start_i    = 1'b0;
        core_eoc_i = 1'b0;
        chk("start_eoc_done", done_o, 0);
        chk("start_eoc_core_rst", core_rst_o, 1);
        chk("start_eoc_busy", busy_o, 1);
        chk("start_eoc_run", run_cycles_o, 0);
        chk("start_eoc_exit", exit_code_o, 0);
        chk("start_eoc_irq", irq_o, 0);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge aclk);
            if (fetch_en_o) ok = 1'b1;
        end
        chk("reboot_reached_run", ok, 1);
        repeat (7) @(negedge aclk);

        // Reset in RUN returns everything to reset values at once.
        areset = 1'b1;
        @(negedge aclk);
        chk("mid_rst_core_rst", core_rst_o, 1);
        chk("mid_rst_fetch", fetch_en_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_timeout", timeout_o, 0);
        chk("mid_rst_run", run_cycles_o, 0);
        chk("mid_rst_exit", exit_code_o, 0);
        chk("mid_rst_boot_addr", boot_addr_o, 0);
        chk("mid_rst_irq", irq_o, 0);
        areset = 1'b0;
        r0 = rel_cnt;
        repeat (20) @(negedge aclk);
        chk("post_rst_idle_busy", busy_o, 0);
        chk("post_rst_no_boot", rel_cnt - r0, 0);

        // EOC in IDLE is ignored.
        core_eoc_i  = 1'b1;
        core_exit_i = 32'd9;
        @(negedge aclk);
        core_eoc_i = 1'b0;
        @(negedge aclk);
        chk("idle_eoc_done", done_o, 0);
        chk("idle_eoc_exit", exit_code_o, 0);
        chk("idle_eoc_irq", irq_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
